cra_seq: RTL and testbench
==========================

// Module: cra_seq
// PURPOSE
//  Parametrised microcode address sequencer; successor to the fixed 11-bit CRA.
//  Forms next CRADR each eboxClk from J, OR-in dispatch bits, trap force and a
//  DEPTH-entry call/return stack, with depth count and sticky over/underflow.
//  Sits between CRM (J/CALL/DISP fields) and CRAM address; stall-aware for MBOX waits.
// PARAMETERS
//  ADR_W   11  CRAM address width; trap vector = all ones ({ADR_W{1'b1}}).
//  DEPTH   16  call/return stack entries (>=2, power of 2 not required).
//  CNT_W   $clog2(DEPTH+1)  width of stackDepth (derived, not overridden).
// PORTS
//  eboxClk     in   1      EBOX clock; all state on posedge.
//  eboxReset   in   1      async active-high reset.
//  stall       in   1      1 = hold all state (CRADR, stack, flags) this cycle.
//  J           in   ADR_W  CRAM J field.
//  dispEn      in   1      OR dispMux into next address.
//  dispMux     in   ADR_W  dispatch/skip bits, pre-decoded upstream.
//  call        in   1      push current CRADR.
//  ret         in   1      pop; next address = top | J.
//  force1777   in   1      trap: next address = all ones; also pushes.
//  clrFlags    in   1      clear stackOvf/stackUnf.
//  diagLd      in   1      (CRA_DIAG_EN) load diagAdr from diagData.
//  diagData    in   ADR_W  (CRA_DIAG_EN) diagnostic address value.
//  diagSel     in   1      (CRA_DIAG_EN) next address = diagAdr.
//  CRADR       out  ADR_W  current CRAM address (registered).
//  sbrRet      out  ADR_W  stack top (0 when empty), combinational from regs.
//  stackDepth  out  CNT_W  valid entries, 0..DEPTH.
//  stackOvf    out  1      sticky: push while full.
//  stackUnf    out  1      sticky: pop while empty.
//  diagRd      out  ADR_W  (CRA_DIAG_EN) diagAdr readback; else 0.
// BEHAVIOUR
//  - Reset (async): CRADR=0, stackDepth=0, ptr=0, flags=0, diagAdr=0; array not cleared.
//  - One-cycle latency: inputs sampled at posedge produce CRADR at that edge.
//  - stall=1 overrides all: no push/pop, flags/diagAdr hold, CRADR holds.
//  - Next-address priority: force1777 > diagSel (CRA_DIAG_EN) > ret > J|(dispEn?dispMux:0).
//    ret path: top|J|(dispEn?dispMux:0). force path ignores J/dispMux.
//  - Push value = CRADR before the edge (address of calling word).
//  - Push when call|force1777; pop when ret & ~force1777.
//  - call&ret same cycle (no force): replace top with CRADR, depth unchanged;
//    if empty: flags stackUnf, write entry, depth becomes 1.
//  - force1777&ret: push only, ret ignored (trap wins).
//  - Circular buffer: push when depth==DEPTH overwrites oldest, depth stays DEPTH,
//    stackOvf<=1. Pop when depth==0: target uses top=0, depth stays 0, stackUnf<=1.
//  - Pointer wraps modulo DEPTH, correct for non-power-of-2 DEPTH.
//  - clrFlags clears flags unless a same-cycle event sets them (set wins).
//  - Reset mid-call: pending push discarded; stack reads empty after release.
// CONFIGURATION
//  CRA_DIAG_EN defined: diagAdr register; diagLd loads diagData (takes effect next
//   cycle); diagSel selects diagAdr as next address (below force1777); diagRd=diagAdr.
//  CRA_DIAG_EN undefined: ports remain, diagLd/diagSel/diagData ignored, diagRd=0,
//   no diagAdr flops.
// TESTING
//  1 Reset mid-run, J=12'o0-style J=11'o123 -> CRADR=0 during reset, 11'o123 one edge after release.
//  2 CRADR=11'o200, call,J=11'o300; then ret,J=11'o001 -> CRADR 11'o300 then 11'o201, depth 1->0.
//  3 DEPTH=4: 5 nested calls -> stackOvf=1, depth=4, 4 rets return newest-first; 5th ret -> stackUnf=1, CRADR=J.
//  4 force1777&ret at CRADR=11'o050 -> CRADR=11'o3777, depth+1, top=11'o050; stall=1 for 3 cycles -> nothing changes.
//  5 dispEn=1,J=11'o400,dispMux=11'o007 -> CRADR=11'o407; call&ret together at depth 2 -> depth 2, top=old CRADR.
//  6 CRA_DIAG_EN: diagLd,diagData=11'o1234 then diagSel -> diagRd=11'o1234, CRADR=11'o1234; undefined -> diagRd=0, CRADR=J.

Source files
------------

// File: rtl/cra_seq.sv
// cra_seq: microcode address sequencer forming the next CRAM address from J, dispatch bits, trap force and a circular call/return stack.
// Define CRA_DIAG_EN to build the diagnostic address register (diagLd/diagData/diagSel/diagRd).
module cra_seq #(
  parameter int ADR_W = 11,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             eboxClk,
  input  logic             eboxReset,
  input  logic             stall,
  input  logic [ADR_W-1:0] J,
  input  logic             dispEn,
  input  logic [ADR_W-1:0] dispMux,
  input  logic             call,
  input  logic             ret,
  input  logic             force1777,
  input  logic             clrFlags,
  input  logic             diagLd,
  input  logic [ADR_W-1:0] diagData,
  input  logic             diagSel,
  output logic [ADR_W-1:0] CRADR,
  output logic [ADR_W-1:0] sbrRet,
  output logic [CNT_W-1:0] stackDepth,
  output logic             stackOvf,
  output logic             stackUnf,
  output logic [ADR_W-1:0] diagRd
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADR_W-1:0] stack_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] inc_ptr;
  logic [PTR_W-1:0] mem_waddr;
  logic             mem_we;
  logic [CNT_W-1:0] depth_nxt;
  logic             stack_empty;
  logic             stack_full;
  logic             push_evt;
  logic             replace_evt;
  logic             pop_evt;
  logic             ovf_set;
  logic             unf_set;
  logic [ADR_W-1:0] top_val;
  logic [ADR_W-1:0] disp_bits;
  logic [ADR_W-1:0] cradr_nxt;
  logic [ADR_W-1:0] diag_adr;

  // wr_ptr is the next free slot; the top entry sits one below it, modulo DEPTH
  assign stack_empty = (stackDepth == '0);
  assign stack_full  = (stackDepth == CNT_FULL);
  assign top_ptr     = (wr_ptr == '0) ? PTR_LAST : wr_ptr - 1'b1;
  assign inc_ptr     = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
  assign top_val     = stack_empty ? '0 : stack_mem[top_ptr];
  assign sbrRet      = top_val;
  assign disp_bits   = dispEn ? dispMux : '0;

  assign push_evt    = force1777 | (call & ~ret);
  assign replace_evt = call & ret & ~force1777;
  assign pop_evt     = ret & ~call & ~force1777;

  always_comb begin
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr;
    wr_ptr_nxt = wr_ptr;
    depth_nxt  = stackDepth;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (push_evt) begin
      // a push while full lands on the oldest slot, which is wr_ptr itself
      mem_we     = 1'b1;
      wr_ptr_nxt = inc_ptr;
      if (stack_full) begin
        ovf_set = 1'b1;
      end else begin
        depth_nxt = stackDepth + 1'b1;
      end
    end else if (replace_evt) begin
      mem_we = 1'b1;
      if (stack_empty) begin
        unf_set    = 1'b1;
        wr_ptr_nxt = inc_ptr;
        depth_nxt  = CNT_W'(1);
      end else begin
        mem_waddr = top_ptr;
      end
    end else if (pop_evt) begin
      if (stack_empty) begin
        unf_set = 1'b1;
      end else begin
        wr_ptr_nxt = top_ptr;
        depth_nxt  = stackDepth - 1'b1;
      end
    end
  end

  always_comb begin
    cradr_nxt = J | disp_bits;
    if (force1777) begin
      cradr_nxt = '1;
`ifdef CRA_DIAG_EN
    end else if (diagSel) begin
      cradr_nxt = diag_adr;
`endif
    end else if (ret) begin
      cradr_nxt = top_val | J | disp_bits;
    end
  end

  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      CRADR      <= '0;
      wr_ptr     <= '0;
      stackDepth <= '0;
      stackOvf   <= 1'b0;
      stackUnf   <= 1'b0;
    end else if (!stall) begin
      CRADR      <= cradr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      stackDepth <= depth_nxt;
      stackOvf   <= ovf_set | (stackOvf & ~clrFlags);
      stackUnf   <= unf_set | (stackUnf & ~clrFlags);
    end
  end

  // Stack contents are not reset; depth alone decides what is valid.
  always_ff @(posedge eboxClk) begin
    if (!eboxReset && !stall && mem_we) begin
      stack_mem[mem_waddr] <= CRADR;
    end
  end

`ifdef CRA_DIAG_EN
  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      diag_adr <= '0;
    end else if (!stall && diagLd) begin
      diag_adr <= diagData;
    end
  end

  assign diagRd = diag_adr;
`else
  logic unused_diag;
  assign diag_adr    = '0;
  assign diagRd      = '0;
  assign unused_diag = ^{diagLd, diagSel, diagData, diag_adr};
`endif

endmodule

// File: tb/tb_cra_seq.sv
// Bench for cra_seq: two instances (DEPTH 4 and 5) driven in parallel, checked against a queue-based stack model.
// Directed scenarios first, then a randomized run with occasional mid-cycle resets.
module tb_cra_seq;

`ifdef CRA_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic        eboxClk = 1'b0;
  logic        eboxReset;
  logic        stall, dispEn, call, ret, force1777, clrFlags, diagLd, diagSel;
  logic [10:0] J, dispMux, diagData;

  logic [10:0] cradr0, sbr0, drd0, cradr1, sbr1, drd1;
  logic [2:0]  dep0, dep1;
  logic        ovf0, unf0, ovf1, unf1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, index 0 = DEPTH 4, index 1 = DEPTH 5
  int          lim [2] = '{4, 5};
  logic [10:0] m_cradr [2];
  logic        m_ovf [2];
  logic        m_unf [2];
  logic [10:0] m_diag [2];
  logic [10:0] q0 [$];
  logic [10:0] q1 [$];

  always #5 eboxClk = ~eboxClk;

  cra_seq #(.ADR_W(11), .DEPTH(4)) u_dut4 (
    .eboxClk(eboxClk), .eboxReset(eboxReset), .stall(stall), .J(J),
    .dispEn(dispEn), .dispMux(dispMux), .call(call), .ret(ret),
    .force1777(force1777), .clrFlags(clrFlags), .diagLd(diagLd),
    .diagData(diagData), .diagSel(diagSel), .CRADR(cradr0), .sbrRet(sbr0),
    .stackDepth(dep0), .stackOvf(ovf0), .stackUnf(unf0), .diagRd(drd0)
  );

  cra_seq #(.ADR_W(11), .DEPTH(5)) u_dut5 (
    .eboxClk(eboxClk), .eboxReset(eboxReset), .stall(stall), .J(J),
    .dispEn(dispEn), .dispMux(dispMux), .call(call), .ret(ret),
    .force1777(force1777), .clrFlags(clrFlags), .diagLd(diagLd),
    .diagData(diagData), .diagSel(diagSel), .CRADR(cradr1), .sbrRet(sbr1),
    .stackDepth(dep1), .stackOvf(ovf1), .stackUnf(unf1), .diagRd(drd1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cradr[k] = '0;
      m_ovf[k]   = 1'b0;
      m_unf[k]   = 1'b0;
      m_diag[k]  = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Stack kept as a queue: newest at the back, oldest dropped from the front on overflow.
  task automatic model_step(input int k);
    logic [10:0] q [$];
    logic [10:0] top, dm, nxt;
    if (eboxReset || stall) return;
    if (k == 0) q = q0; else q = q1;
    top = (q.size() > 0) ? q[q.size()-1] : 11'd0;
    dm  = dispEn ? dispMux : 11'd0;
    if (clrFlags) begin
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
    end
    if (force1777)             nxt = 11'h7FF;
    else if (DIAG && diagSel)  nxt = m_diag[k];
    else if (ret)              nxt = top | J | dm;
    else                       nxt = J | dm;
    if (force1777 || (call && !ret)) begin
      if (q.size() == lim[k]) begin
        m_ovf[k] = 1'b1;
        void'(q.pop_front());
      end
      q.push_back(m_cradr[k]);
    end else if (call && ret) begin
      if (q.size() == 0) begin
        m_unf[k] = 1'b1;
        q.push_back(m_cradr[k]);
      end else begin
        q[q.size()-1] = m_cradr[k];
      end
    end else if (ret) begin
      if (q.size() == 0) m_unf[k] = 1'b1;
      else void'(q.pop_back());
    end
    if (DIAG && diagLd) m_diag[k] = diagData;
    m_cradr[k] = nxt;
    if (k == 0) q0 = q; else q1 = q;
  endtask

  task automatic check_all();
    chk("d4_cradr", cradr0, m_cradr[0]);
    chk("d4_sbrret", sbr0, (q0.size() > 0) ? q0[q0.size()-1] : 11'd0);
    chk("d4_depth", dep0, q0.size());
    chk("d4_ovf", ovf0, m_ovf[0]);
    chk("d4_unf", unf0, m_unf[0]);
    chk("d4_diagrd", drd0, DIAG ? m_diag[0] : 11'd0);
    chk("d5_cradr", cradr1, m_cradr[1]);
    chk("d5_sbrret", sbr1, (q1.size() > 0) ? q1[q1.size()-1] : 11'd0);
    chk("d5_depth", dep1, q1.size());
    chk("d5_ovf", ovf1, m_ovf[1]);
    chk("d5_unf", unf1, m_unf[1]);
    chk("d5_diagrd", drd1, DIAG ? m_diag[1] : 11'd0);
  endtask

  task automatic tick();
    @(posedge eboxClk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  // Asserts reset between edges, holds it across one edge, releases between edges.
  task automatic reset_pulse();
    #2 eboxReset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge eboxClk);
    #1;
    check_all();
    #2 eboxReset = 1'b0;
  endtask

  task automatic idle_inputs();
    stall = 0; dispEn = 0; call = 0; ret = 0; force1777 = 0;
    clrFlags = 0; diagLd = 0; diagSel = 0;
    J = '0; dispMux = '0; diagData = '0;
  endtask

  initial begin
    idle_inputs();
    eboxReset = 1'b1;
    model_reset();

    // reset held, then released with J=o123 waiting
    J = 11'o123;
    @(posedge eboxClk);
    #1;
    check_all();
    chk("t1_cradr_in_reset", cradr0, 11'o0);
    #2 eboxReset = 1'b0;
    tick();
    chk("t1_cradr_after", cradr0, 11'o123);
    reset_pulse();
    chk("t1_cradr_midrun", cradr0, 11'o0);
    tick();
    chk("t1_cradr_release", cradr0, 11'o123);

    // call then return
    J = 11'o200; tick();
    call = 1; J = 11'o300; tick();
    chk("t2_call_cradr", cradr0, 11'o300);
    chk("t2_call_depth", dep0, 3'd1);
    call = 0; ret = 1; J = 11'o001; tick();
    chk("t2_ret_cradr", cradr0, 11'o201);
    chk("t2_ret_depth", dep0, 3'd0);
    ret = 0;

    // overflow and underflow on the 4-deep instance
    reset_pulse();
    J = 11'o100; tick();
    for (int i = 1; i <= 5; i++) begin
      call = 1; J = 11'(i * 8 + 64); tick();
    end
    call = 0;
    chk("t3_ovf", ovf0, 1'b1);
    chk("t3_depth_full", dep0, 3'd4);
    for (int i = 0; i < 4; i++) begin
      ret = 1; J = 11'o0; tick();
      chk("t3_ret_order", cradr0, 11'(11'o140 - 11'(i * 8)));
    end
    J = 11'o77; tick();
    chk("t3_unf", unf0, 1'b1);
    chk("t3_unf_cradr", cradr0, 11'o77);
    chk("t3_d5_oldest", cradr1, 11'o177);
    ret = 0; clrFlags = 1; tick();
    chk("t3_clr", unf0, 1'b0);
    clrFlags = 0;

    // trap wins over return, then stall freezes everything
    J = 11'o050; tick();
    force1777 = 1; ret = 1; J = 11'o012; tick();
    chk("t4_force_cradr", cradr0, 11'o3777);
    chk("t4_force_depth", dep0, 3'd1);
    chk("t4_force_top", sbr0, 11'o050);
    force1777 = 0; ret = 0;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      call = 1'($urandom); ret = 1'($urandom); force1777 = 1'($urandom);
      clrFlags = 1'($urandom); diagLd = 1; diagData = 11'($urandom);
      J = 11'($urandom); tick();
    end
    chk("t4_stall_cradr", cradr0, 11'o3777);
    chk("t4_stall_depth", dep0, 3'd1);
    idle_inputs();

    // dispatch OR, then call and return in the same cycle
    reset_pulse();
    dispEn = 1; J = 11'o400; dispMux = 11'o007; tick();
    chk("t5_disp", cradr0, 11'o407);
    dispEn = 0; call = 1; J = 11'o010; tick();
    J = 11'o020; tick();
    ret = 1; J = 11'o0; tick();
    chk("t5_cr_cradr", cradr0, 11'o010);
    chk("t5_cr_depth", dep0, 3'd2);
    chk("t5_cr_top", sbr0, 11'o020);
    call = 0; ret = 0;

    // diagnostic address
    diagLd = 1; diagData = 11'o1234; J = 11'o055; tick();
    diagLd = 0; diagSel = 1; J = 11'o066; tick();
`ifdef CRA_DIAG_EN
    chk("t6_diagrd", drd0, 11'o1234);
    chk("t6_diag_cradr", cradr0, 11'o1234);
`else
    chk("t6_diagrd", drd0, 11'o0);
    chk("t6_diag_cradr", cradr0, 11'o066);
`endif
    diagSel = 0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      stall     = ($urandom_range(0, 7) == 0);
      call      = ($urandom_range(0, 2) == 0);
      ret       = ($urandom_range(0, 2) == 0);
      force1777 = ($urandom_range(0, 15) == 0);
      clrFlags  = ($urandom_range(0, 9) == 0);
      dispEn    = 1'($urandom);
      dispMux   = 11'($urandom_range(0, 15));
      J         = 11'($urandom);
      diagLd    = ($urandom_range(0, 7) == 0);
      diagSel   = ($urandom_range(0, 7) == 0);
      diagData  = 11'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        call = 1;
        reset_pulse();
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
